// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port synchronous data memory (registered address, one
// cycle read latency) between the processor and one auxiliary requester.
// Each cycle the winner is picked combinationally and its address, write data
// and write enable are muxed onto the memory port. Read data comes back in the
// following cycle, steered to the requester that owned the read.
//
// Ports
//   clock, reset              arbiter clock (dmem edge), async active-high reset
//   p_req/p_we/p_addr/p_wdata processor request fields
//   p_gnt/p_rvalid/p_rdata    processor grant, read-valid strobe, read data
//   a_req/a_we/a_addr/a_wdata aux request fields
//   a_lock                    aux asks to keep ownership on later cycles
//   a_gnt/a_rvalid/a_rdata    aux grant, read-valid strobe, read data
//   address_dmem/data/wren    memory address, write data, write enable
//   q_dmem                    memory read data
//
// Arbitration when both request:
//   lock held and burst budget left    -> aux
//   lock held and budget exhausted     -> processor (lock then drops)
//   no lock, PROC_PRIORITY = 1         -> processor
//   no lock, PROC_PRIORITY = 0         -> whoever did not own the last grant
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 32,
  parameter int PROC_PRIORITY = 0,
  parameter int MAX_BURST     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {OWNER_PROC = 1'b0, OWNER_AUX = 1'b1} owner_t;

  owner_t            last_owner_reg;
  logic              lock_active_reg;
  logic [CNT_W-1:0]  burst_cnt_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] data_hold_reg;

  logic              p_win;
  logic              a_win;
  logic              burst_full;

  // Channel 0 = processor, channel 1 = aux; used by the read-return slices.
  logic [1:0]        win;
  logic [1:0]        req_we;
  logic [DATA_W-1:0] rdata_out [2];
  logic [1:0]        rvalid_out;

  assign burst_full = (burst_cnt_reg == CNT_W'(MAX_BURST));

  // ---------------------------------------------------------------------------
  // Winner selection. Grants are forced low while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    p_win = 1'b0;
    a_win = 1'b0;
    if (!reset) begin
      if (p_req && !a_req) begin
        p_win = 1'b1;
      end else if (a_req && !p_req) begin
        a_win = 1'b1;
      end else if (p_req && a_req) begin
        if (lock_active_reg) begin
          // Lock overrides both fairness and processor priority until the
          // aux has used up its burst budget.
          if (burst_full) p_win = 1'b1;
          else            a_win = 1'b1;
        end else if (PROC_PRIORITY != 0) begin
          p_win = 1'b1;
        end else if (last_owner_reg == OWNER_AUX) begin
          p_win = 1'b1;
        end else begin
          a_win = 1'b1;
        end
      end
    end
  end

  assign p_gnt  = p_win;
  assign a_gnt  = a_win;
  assign win    = {a_win, p_win};
  assign req_we = {a_we, p_we};

  // ---------------------------------------------------------------------------
  // Memory port mux. Idle cycles replay the last driven address/data so the
  // memory inputs do not toggle when nobody is asking.
  // ---------------------------------------------------------------------------
  always_comb begin
    address_dmem = addr_hold_reg;
    data         = data_hold_reg;
    wren         = 1'b0;
    if (reset) begin
      address_dmem = '0;
      data         = '0;
    end else if (p_win) begin
      address_dmem = p_addr;
      data         = p_wdata;
      wren         = p_we;
    end else if (a_win) begin
      address_dmem = a_addr;
      data         = a_wdata;
      wren         = a_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Ownership, lock and burst bookkeeping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_owner_reg  <= OWNER_AUX;   // processor wins the first tie
      lock_active_reg <= 1'b0;
      burst_cnt_reg   <= '0;
      addr_hold_reg   <= '0;
      data_hold_reg   <= '0;
    end else begin
      if (p_win || a_win) begin
        last_owner_reg <= a_win ? OWNER_AUX : OWNER_PROC;
        addr_hold_reg  <= address_dmem;
        data_hold_reg  <= data;
      end

      lock_active_reg <= a_win & a_lock;

      // Only locked aux grants that actually held off a waiting processor
      // consume budget; an aux alone on the bus may keep it indefinitely.
      if (p_win || !a_lock) begin
        burst_cnt_reg <= '0;
      end else if (a_win && p_req && lock_active_reg && !burst_full) begin
        burst_cnt_reg <= burst_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return, one slice per requester. The valid strobe is registered at
  // the grant edge; the data is taken straight from the memory output while
  // valid (it is stable for that whole cycle) and captured into a hold
  // register so it keeps its value afterwards.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_hold_reg;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rvalid_reg     <= 1'b0;
        rdata_hold_reg <= '0;
      end else begin
        rvalid_reg <= win[gi] & ~req_we[gi];
        if (rvalid_reg) begin
          rdata_hold_reg <= q_dmem;
        end
      end
    end

    assign rvalid_out[gi] = rvalid_reg;
    assign rdata_out[gi]  = rvalid_reg ? q_dmem : rdata_hold_reg;
  end

  assign p_rvalid = rvalid_out[0];
  assign a_rvalid = rvalid_out[1];
  assign p_rdata  = rdata_out[0];
  assign a_rdata  = rdata_out[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives a round-robin arbiter and a processor-priority arbiter with the same
// request stimulus. The round-robin one is checked every cycle against a
// behavioural model (winner rules, lock budget, shadow copy of memory); the
// priority one is checked in its own scenario.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;

  logic              clk;
  logic              reset;
  logic              p_req, p_we, a_req, a_we, a_lock;
  logic [ADDR_W-1:0] p_addr, a_addr;
  logic [DATA_W-1:0] p_wdata, a_wdata;
  logic              p_gnt, p_rvalid, a_gnt, a_rvalid, wren;
  logic [DATA_W-1:0] p_rdata, a_rdata, data, q_dmem;
  logic [ADDR_W-1:0] address_dmem;

  logic              pp_p_gnt, pp_p_rvalid, pp_a_gnt, pp_a_rvalid, pp_wren;
  logic [DATA_W-1:0] pp_p_rdata, pp_a_rdata, pp_data;
  logic [ADDR_W-1:0] pp_address;

  // Memory model for the checked instance.
  logic [DATA_W-1:0] mem [4096];
  logic              pre_en;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;

  // Reference model state.
  logic [DATA_W-1:0] shadow [4096];
  logic              m_last_aux, m_lock, m_pv, m_av;
  int                m_burst;
  logic [DATA_W-1:0] m_prd, m_ard;

  // Observed grants of the latest step.
  logic obs_p, obs_a, obs_wren, obs_pp_p, obs_pp_a, obs_pp_wren;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROC_PRIORITY(0), .MAX_BURST(MAX_BURST)) dut (
    .clock(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROC_PRIORITY(1), .MAX_BURST(MAX_BURST)) dut_pp (
    .clock(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(pp_p_gnt), .p_rvalid(pp_p_rvalid), .p_rdata(pp_p_rdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_gnt(pp_a_gnt), .a_rvalid(pp_a_rvalid), .a_rdata(pp_a_rdata),
    .address_dmem(pp_address), .data(pp_data), .wren(pp_wren), .q_dmem(q_dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  task automatic model_reset();
    m_last_aux = 1'b1;
    m_lock     = 1'b0;
    m_burst    = 0;
    m_pv       = 1'b0;
    m_av       = 1'b0;
    m_prd      = '0;
    m_ard      = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p_req = 0; a_req = 0; p_we = 0; a_we = 0; a_lock = 0;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
  endtask

  // One bus cycle: drive, check grants/memory port, clock, check read return.
  task automatic step(input logic preq, input logic pwe, input logic [ADDR_W-1:0] paddr,
                      input logic [DATA_W-1:0] pwd, input logic areq, input logic awe,
                      input logic [ADDR_W-1:0] aaddr, input logic [DATA_W-1:0] awd,
                      input logic alock);
    int w;
    logic exp_we;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    p_req = preq; p_we = pwe; p_addr = paddr; p_wdata = pwd;
    a_req = areq; a_we = awe; a_addr = aaddr; a_wdata = awd; a_lock = alock;
    #3;
    // Who should own this cycle (0 none, 1 processor, 2 aux).
    if (preq && !areq) w = 1;
    else if (areq && !preq) w = 2;
    else if (preq && areq) begin
      if (m_lock) w = (m_burst < MAX_BURST) ? 2 : 1;
      else        w = m_last_aux ? 1 : 2;
    end else w = 0;
    ea = (w == 1) ? paddr : aaddr;
    ed = (w == 1) ? pwd : awd;
    exp_we = (w == 1) ? pwe : ((w == 2) ? awe : 1'b0);
    obs_p = p_gnt; obs_a = a_gnt; obs_wren = wren;
    obs_pp_p = pp_p_gnt; obs_pp_a = pp_a_gnt; obs_pp_wren = pp_wren;

    checks++;
    if ({p_gnt, a_gnt} !== {w == 1, w == 2})
      $display("FAIL gnt cyc=%0d got p=%b a=%b want p=%b a=%b", cyc, p_gnt, a_gnt, w == 1, w == 2);
    else passes++;
    checks++;
    if (wren !== exp_we) $display("FAIL wren cyc=%0d got %b want %b", cyc, wren, exp_we);
    else passes++;
    if (w != 0) begin
      checks++;
      if (address_dmem !== ea) $display("FAIL addr cyc=%0d got %h want %h", cyc, address_dmem, ea);
      else passes++;
      if (exp_we) begin
        checks++;
        if (data !== ed) $display("FAIL wdata cyc=%0d got %h want %h", cyc, data, ed);
        else passes++;
      end
    end

    @(posedge clk); #1;
    cyc++;
    if (w != 0) begin
      m_last_aux = (w == 2);
      m_pv = (w == 1) && !pwe;
      m_av = (w == 2) && !awe;
      if (m_pv) m_prd = shadow[ea];
      if (m_av) m_ard = shadow[ea];
      if (exp_we) shadow[ea] = ed;
    end else begin
      m_pv = 1'b0;
      m_av = 1'b0;
    end
    if (w == 1 || !alock) m_burst = 0;
    else if (w == 2 && preq && m_lock && m_burst < MAX_BURST) m_burst++;
    m_lock = (w == 2) && alock;

    checks++;
    if ({p_rvalid, a_rvalid} !== {m_pv, m_av})
      $display("FAIL rvalid cyc=%0d got p=%b a=%b want p=%b a=%b", cyc, p_rvalid, a_rvalid, m_pv, m_av);
    else passes++;
    checks++;
    if (p_rdata !== m_prd) $display("FAIL p_rdata cyc=%0d got %h want %h", cyc, p_rdata, m_prd);
    else passes++;
    checks++;
    if (a_rdata !== m_ard) $display("FAIL a_rdata cyc=%0d got %h want %h", cyc, a_rdata, m_ard);
    else passes++;
    $display("cyc %0d p_req=%b a_req=%b lock=%b -> p_gnt=%b a_gnt=%b p_rv=%b a_rv=%b",
             cyc, preq, areq, alock, obs_p, obs_a, p_rvalid, a_rvalid);
  endtask

  task automatic test_reset();
    p_req = 1; a_req = 1; p_addr = 12'h3c; a_addr = 12'h2a; p_wdata = 32'h1; a_wdata = 32'h2;
    p_we = 1; a_we = 1; a_lock = 1;
    #2;
    checks++;
    if ({p_gnt, a_gnt, wren, p_rvalid, a_rvalid} !== 5'b0 || address_dmem !== '0 || data !== '0 ||
        p_rdata !== '0 || a_rdata !== '0 || {pp_p_gnt, pp_a_gnt} !== 2'b0)
      $display("FAIL reset_state got gnt=%b%b wren=%b rv=%b%b addr=%h data=%h want all 0",
               p_gnt, a_gnt, wren, p_rvalid, a_rvalid, address_dmem, data);
    else passes++;
    do_reset();
  endtask

  task automatic test_single_read();
    step(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 0);
    checks++;
    if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEADBEEF || a_rvalid !== 1'b0)
      $display("FAIL single_read got rv=%b data=%h a_rv=%b want 1 deadbeef 0", p_rvalid, p_rdata, a_rvalid);
    else passes++;
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, ADDR_W'($urandom_range(0, 63)), 32'h0, 1, 0, ADDR_W'($urandom_range(0, 63)), 32'h0, 0);
      checks++;
      if (obs_p !== ((i % 2) == 0))
        $display("FAIL alternate i=%0d got p_gnt=%b want %b", i, obs_p, (i % 2) == 0);
      else passes++;
    end
  endtask

  task automatic test_write_then_read();
    step(0, 0, 12'h0, 32'h0, 1, 1, 12'h020, 32'h12345678, 0);
    checks++;
    if (obs_wren !== 1'b1) $display("FAIL aux_write wren got %b want 1", obs_wren);
    else passes++;
    step(1, 0, 12'h020, 32'h0, 0, 0, 12'h0, 32'h0, 0);
    checks++;
    if (obs_wren !== 1'b0 || p_rdata !== 32'h12345678)
      $display("FAIL read_back got wren=%b data=%h want 0 12345678", obs_wren, p_rdata);
    else passes++;
  endtask

  task automatic test_lock_burst();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 12'h0, 32'h0, 1, 0, ADDR_W'($urandom_range(0, 63)), 32'h0, 1);
      checks++;
      if (obs_a !== 1'b1) $display("FAIL aux_hold i=%0d got a_gnt=%b want 1", i, obs_a);
      else passes++;
    end
    for (int i = 0; i < 12; i++) begin
      step(1, 0, ADDR_W'($urandom_range(0, 63)), 32'h0, 1, 0, ADDR_W'($urandom_range(0, 63)), 32'h0, 1);
      if (i <= 9) begin
        checks++;
        if (obs_p !== (i == 8) || obs_a !== (i != 8))
          $display("FAIL burst i=%0d got p=%b a=%b want p=%b a=%b", i, obs_p, obs_a, i == 8, i != 8);
        else passes++;
      end
    end
    step(1, 0, 12'h5, 32'h0, 1, 0, 12'h6, 32'h0, 0);
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, ADDR_W'($urandom_range(0, 63)), 32'h0, 1, 0, ADDR_W'($urandom_range(0, 63)), 32'h0, 0);
      checks++;
      if (obs_pp_p !== 1'b1 || obs_pp_a !== 1'b0 || obs_pp_wren !== 1'b0)
        $display("FAIL priority i=%0d got p=%b a=%b wren=%b want 1 0 0", i, obs_pp_p, obs_pp_a, obs_pp_wren);
      else passes++;
    end
    step(0, 0, 12'h0, 32'h0, 1, 0, 12'h7, 32'h0, 0);
    checks++;
    if (obs_pp_a !== 1'b1 || obs_pp_p !== 1'b0)
      $display("FAIL priority_release got p=%b a=%b want 0 1", obs_pp_p, obs_pp_a);
    else passes++;
  endtask

  task automatic test_random();
    logic [8:0] r;
    for (int i = 0; i < 60; i++) begin
      r = 9'($urandom);
      step(r[0], r[1], ADDR_W'($urandom_range(0, 63)), $urandom,
           r[2] | r[3], r[4] & r[5], ADDR_W'($urandom_range(0, 63)), $urandom, r[6] | r[7]);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 0);
    #1;
    p_req = 1; a_req = 1; p_we = 1; a_we = 0; a_lock = 0;
    reset = 1'b1;
    #1;
    checks++;
    if ({p_rvalid, a_rvalid, p_gnt, a_gnt, wren} !== 5'b0 || address_dmem !== '0 || p_rdata !== '0)
      $display("FAIL reset_mid got rv=%b%b gnt=%b%b wren=%b addr=%h rdata=%h want 0",
               p_rvalid, a_rvalid, p_gnt, a_gnt, wren, address_dmem, p_rdata);
    else passes++;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 0, 12'h011, 32'h0, 1, 0, 12'h012, 32'h0, 0);
    checks++;
    if (obs_p !== 1'b1 || obs_a !== 1'b0)
      $display("FAIL post_reset_tie got p=%b a=%b want 1 0", obs_p, obs_a);
    else passes++;
  endtask

  initial begin
    reset = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_lock = 0;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      pre_en = 1'b1;
      pre_addr = ADDR_W'(i);
      pre_data = (i == 16) ? 32'hDEADBEEF : $urandom;
      shadow[i] = pre_data;
      @(posedge clk); #1;
    end
    pre_en = 1'b0;

    test_reset();
    test_single_read();
    test_alternate();
    test_write_then_read();
    test_lock_burst();
    test_priority();
    test_random();
    test_reset_mid();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
